icache_dm: RTL and testbench
============================

Name: icache_dm

Overview:
- Direct-mapped, one-word-per-block instruction cache between the pipeline's fetch port and the memory controller's instruction port.
- Consumes the fetch request (imemREN, imemaddr) and returns ihit/imemload.
- On a miss, runs a blocking single-word fill from the memory controller.
- Provides a bulk invalidate and saturating hit/miss counters for performance checks.

Parameters:
- SETS, 16, number of blocks; power of two, at least 2.
- CNT_W, 16, width of the hit and miss counters.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- imemREN  in  1  fetch request from the pipeline.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- halt  in  1  pipeline halted; no new misses are started.
- iinval  in  1  invalidate all blocks.
- ihit  out  1  requested word valid this cycle.
- imemload  out  32  instruction word; 0 when ihit is 0.
- iREN  out  1  read request to the memory controller.
- iaddr  out  32  word-aligned fill address.
- iwait  in  1  memory controller busy; fill data is valid on the cycle iwait is 0.
- iload  in  32  fill data.
- hit_count  out  CNT_W  saturating hit counter.
- miss_count  out  CNT_W  saturating miss counter.

Behaviour:
- Address split, with IW = log2(SETS):
  - index = imemaddr[IW+1:2]
  - tag = imemaddr[31:IW+2]
- Storage per set: valid bit, tag, 32-bit data word.
- Reset values:
  - all valid bits 0; tag and data arrays need no reset
  - state IDLE; iREN 0; iaddr 0; ihit 0; imemload 0
  - counters 0; miss address register 0; drop flag 0
- Hit path is combinational, zero latency: ihit = state==IDLE && imemREN && valid[index] && tag match. imemload = data[index] when ihit, else 0.
- State machine with two states, IDLE and FETCH.
- IDLE:
  - If imemREN && !hit && !halt && !iinval, latch {imemaddr[31:2],2'b00} into miss_addr and go to FETCH.
  - Otherwise stay in IDLE.
  - halt blocks new misses; hits are still served.
- FETCH:
  - iREN = 1 and iaddr = miss_addr; both are 0 in IDLE.
  - ihit is forced to 0.
  - When iwait == 0: write iload, tag, and valid=1 into set miss_addr[IW+1:2], unless the drop flag is set. Then go to IDLE.
  - While iwait == 1, stay in FETCH.
- Miss latency: the miss is seen in cycle 0 and the FETCH state is entered at cycle 1. If iwait is 0 at cycle k, ihit is asserted at cycle k+1, provided the request address is unchanged.
- Request change or removal during FETCH: the fill still completes using miss_addr. A memory read is never aborted.
- Invalidate:
  - iinval clears every valid bit at the next edge, in either state.
  - If iinval is seen in FETCH, or in the same cycle as the fill completes, set the drop flag. The in-flight fill is then discarded and its valid bit stays 0.
  - The drop flag clears on return to IDLE.
  - ihit is 0 in any cycle where iinval is 1.
- Counters:
  - hit_count increments once per cycle that ihit is 1.
  - miss_count increments once per IDLE-to-FETCH transition.
  - Both saturate at all-ones and never wrap.
- Reset mid-fill: state returns to IDLE, iREN drops immediately (asynchronous), and the fill is lost. The memory controller tolerates this.
- Simultaneous events:
  - iinval in IDLE with a missing request: iinval wins and no miss starts that cycle.
  - halt in FETCH: the fill still finishes.

Decomposition:
- The package holds:
  - typedef icache_state_t {IDLE, FETCH}
  - function/constant to derive IW from SETS
  - struct icache_addr_t {tag, idx, bytoff}, parametrised via the package's localparams for the default SETS=16
  - struct icache_frame_t {valid, tag, data}
- One natural sub-module: sat_counter (parameter W; inputs inc, RST; output count), instantiated twice for the counters.

Test Plan:
- Cold miss:
  - Stimulus: reset; imemREN=1, imemaddr=0x0000_0040; memory holds 0xDEADBEEF with iwait high for 3 cycles.
  - Required: iREN=1 and iaddr=0x40 for 4 cycles; ihit=1 and imemload=0xDEADBEEF on the following cycle; miss_count=1.
- Hit and conflict:
  - Stimulus: after filling 0x40, request 0x40 again, then 0x80.
  - Required: 0x40 hits with 0 latency. 0x80 uses the same index with a different tag, so it misses and replaces the block. A later request to 0x40 misses again.
- Address change mid-fill:
  - Stimulus: miss on 0x100; while in FETCH, imemaddr changes to 0x200.
  - Required: iaddr stays 0x100 and set 0 gets the 0x100 data. Next cycle in IDLE, 0x200 misses.
- Invalidate during fill:
  - Stimulus: miss on 0x44; pulse iinval in the second FETCH cycle; complete the fill.
  - Required: no valid blocks remain, and a re-request of 0x44 misses again.
- Halt:
  - Stimulus: halt=1 with a miss on 0x300 and a hit on a resident address.
  - Required: iREN stays 0 for 0x300 and miss_count is unchanged. The resident address still returns ihit=1.
- Saturation and reset:
  - Stimulus: with CNT_W=4, drive 20 consecutive hit cycles; then assert RST while in FETCH.
  - Required: hit_count stays at 15. On RST, iREN goes to 0 without waiting for an edge, counters reset to 0, and all valid bits clear.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
//   icache_state_t : fill controller states (IDLE, FETCH)
//   icache_iw()    : index width derived from the number of sets
//   icache_addr_t  : fetch address split for the default geometry
//   icache_frame_t : one cache block as read out of the arrays
package icache_pkg;

  typedef enum logic [0:0] {
    IDLE,
    FETCH
  } icache_state_t;

  function automatic int unsigned icache_iw(input int unsigned sets);
    return $clog2(sets);
  endfunction

  localparam int unsigned SETS_DEF  = 16;
  localparam int unsigned IW_DEF    = icache_iw(SETS_DEF);
  localparam int unsigned TAG_W_DEF = 32 - IW_DEF - 2;
  // Widest tag any legal geometry can have (SETS >= 2 gives IW >= 1).
  localparam int unsigned MAX_TAG_W = 29;

  typedef struct packed {
    logic [TAG_W_DEF-1:0] tag;
    logic [IW_DEF-1:0]    idx;
    logic [1:0]           bytoff;
  } icache_addr_t;

  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
    logic [31:0]          data;
  } icache_frame_t;

endpackage

// File: rtl/icache_dm_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
//   CLK   : clock
//   RST   : asynchronous active-high reset, clears the count
//   inc   : increment request for this cycle
//   count : current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-block instruction cache.
//   CLK, RST           : clock, asynchronous active-high reset
//   imemREN, imemaddr  : fetch request from the pipeline
//   halt               : blocks new misses (hits still served)
//   iinval             : invalidate every block
//   ihit, imemload     : zero-latency hit and word (word is 0 without a hit)
//   iREN, iaddr        : single-word fill request to the memory controller
//   iwait, iload       : fill handshake; data valid when iwait is 0
//   hit_count          : saturating count of hit cycles
//   miss_count         : saturating count of started fills
module icache_dm
  import icache_pkg::*;
#(
  parameter int unsigned SETS  = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  input  logic             halt,
  input  logic             iinval,
  output logic             ihit,
  output logic [31:0]      imemload,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             iwait,
  input  logic [31:0]      iload,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int unsigned IW = icache_iw(SETS);
  localparam int unsigned TW = 30 - IW;

  icache_state_t state_q, state_d;
  logic [31:0]   miss_addr_q, miss_addr_d;
  logic          drop_q, drop_d;
  logic [SETS-1:0] valid_q, valid_d;
  logic [TW-1:0] tag_q  [SETS];
  logic [31:0]   data_q [SETS];

  logic [IW-1:0] req_idx, fill_idx;
  logic [TW-1:0] req_tag, fill_tag;
  icache_frame_t rd_frame;
  logic          hit;
  logic          fill_we;
  logic          miss_start;
  logic          unused_addr_bits;

  assign req_idx  = imemaddr[IW+1:2];
  assign req_tag  = imemaddr[31:IW+2];
  assign fill_idx = miss_addr_q[IW+1:2];
  assign fill_tag = miss_addr_q[31:IW+2];
  assign unused_addr_bits = ^imemaddr[1:0];

  always_comb begin
    rd_frame.valid = valid_q[req_idx];
    rd_frame.tag   = MAX_TAG_W'(tag_q[req_idx]);
    rd_frame.data  = data_q[req_idx];
  end

  // An invalidate in the same cycle wins over the hit it would otherwise produce.
  assign hit = (state_q == IDLE) && imemREN && !iinval && rd_frame.valid &&
               (rd_frame.tag == MAX_TAG_W'(req_tag));

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    drop_d      = drop_q;
    fill_we     = 1'b0;
    miss_start  = 1'b0;
    unique case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (imemREN && !hit && !halt && !iinval) begin
          miss_addr_d = {imemaddr[31:2], 2'b00};
          state_d     = FETCH;
          miss_start  = 1'b1;
        end
      end
      FETCH: begin
        if (!iwait) begin
          // A fill that overlapped an invalidate may hold pre-invalidate data.
          fill_we = !(drop_q || iinval);
          drop_d  = 1'b0;
          state_d = IDLE;
        end else begin
          drop_d = drop_q || iinval;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    if (fill_we) begin
      valid_d[fill_idx] = 1'b1;
    end
    if (iinval) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      drop_q      <= 1'b0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      drop_q      <= drop_d;
      valid_q     <= valid_d;
    end
  end

  // Tag and data need no reset: valid gates every use.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

  assign ihit     = hit;
  assign imemload = hit ? rd_frame.data : 32'h0;
  assign iREN     = (state_q == FETCH);
  assign iaddr    = (state_q == FETCH) ? miss_addr_q : 32'h0;

  sat_counter #(
    .W(CNT_W)
  ) u_hit_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .inc  (hit),
    .count(hit_count)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_miss_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .inc  (miss_start),
    .count(miss_count)
  );

endmodule

// File: tb/tb_icache_dm.sv
module tb_icache_dm;

  localparam int unsigned SETS  = 16;
  localparam int unsigned CNT_W = 4;

  logic             CLK;
  logic             RST;
  logic             imemREN;
  logic [31:0]      imemaddr;
  logic             halt;
  logic             iinval;
  logic             ihit;
  logic [31:0]      imemload;
  logic             iREN;
  logic [31:0]      iaddr;
  logic             iwait;
  logic [31:0]      iload;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  int checks = 0;
  int errors = 0;

  icache_dm #(
    .SETS (SETS),
    .CNT_W(CNT_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .halt      (halt),
    .iinval    (iinval),
    .ihit      (ihit),
    .imemload  (imemload),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Backing memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) + 32'h01234567;
  endfunction

  assign iload = mem_word(iaddr);

  // Reference model: each set remembers which word address it holds.
  bit          m_valid [SETS];
  logic [29:0] m_line  [SETS];
  logic [31:0] m_data  [SETS];
  bit          m_pend;
  logic [31:0] m_pend_addr;
  bit          m_drop;
  int          m_hits;
  int          m_misses;
  int          iren_cycles;

  function automatic int sat(input int v);
    return (v > (2 ** CNT_W) - 1) ? (2 ** CNT_W) - 1 : v;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) m_valid[s] = 0;
    m_pend = 0; m_pend_addr = 0; m_drop = 0; m_hits = 0; m_misses = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare one cycle against the model, then advance the model and the clock.
  task automatic tick();
    int          set;
    bit          e_hit;
    logic [31:0] e_load;
    #2;
    set    = int'((imemaddr >> 2) % SETS);
    e_hit  = !m_pend && imemREN && !iinval && m_valid[set] && (m_line[set] == imemaddr[31:2]);
    e_load = e_hit ? m_data[set] : 32'h0;
    check("ihit", {31'b0, ihit}, {31'b0, e_hit});
    check("imemload", imemload, e_load);
    check("iREN", {31'b0, iREN}, {31'b0, m_pend});
    check("iaddr", iaddr, m_pend ? m_pend_addr : 32'h0);
    check("hit_count", 32'(hit_count), 32'(sat(m_hits)));
    check("miss_count", 32'(miss_count), 32'(sat(m_misses)));
    if (iREN) iren_cycles++;
    if (e_hit) m_hits = sat(m_hits + 1);
    if (m_pend) begin
      if (!iwait) begin
        if (!(m_drop || iinval)) begin
          set         = int'((m_pend_addr >> 2) % SETS);
          m_valid[set] = 1;
          m_line[set]  = m_pend_addr[31:2];
          m_data[set]  = mem_word(m_pend_addr);
        end
        m_pend = 0;
        m_drop = 0;
      end else begin
        m_drop = m_drop || iinval;
      end
    end else if (imemREN && !e_hit && !halt && !iinval) begin
      m_pend      = 1;
      m_pend_addr = {imemaddr[31:2], 2'b00};
      m_misses    = sat(m_misses + 1);
    end
    if (iinval) for (int s = 0; s < SETS; s++) m_valid[s] = 0;
    @(posedge CLK);
    #1;
  endtask

  // Request addr: miss cycle, `waits` busy cycles, completion cycle.
  task automatic miss_fill(input logic [31:0] addr, input int waits);
    imemREN = 1; imemaddr = addr; iwait = 1;
    tick();
    repeat (waits) tick();
    iwait = 0;
    tick();
  endtask

  initial begin
    RST = 1; imemREN = 0; imemaddr = 0; halt = 0; iinval = 0; iwait = 1;
    model_reset();
    iren_cycles = 0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 0;
    tick();

    // Cold miss with three busy cycles.
    iren_cycles = 0;
    miss_fill(32'h40, 3);
    check("cold_iren_cycles", 32'(iren_cycles), 32'd4);
    tick();
    check("cold_hit", {31'b0, ihit}, 32'd1);
    check("cold_data", imemload, 32'hDEADBEEF);
    check("cold_miss_count", 32'(miss_count), 32'd1);

    // Hit, then conflicting tag in the same set, then the original misses again.
    imemaddr = 32'h40; tick();
    miss_fill(32'h80, 1);
    tick();
    miss_fill(32'h40, 0);
    tick();

    // Request address moves while the fill is in flight.
    imemaddr = 32'h100; iwait = 1;
    tick();
    imemaddr = 32'h200;
    tick();
    tick();
    iwait = 0;
    tick();
    check("chg_no_hit", {31'b0, ihit}, 32'd0);
    miss_fill(32'h200, 0);
    imemaddr = 32'h100; tick();

    // Invalidate in the second busy cycle drops the fill.
    imemaddr = 32'h44; iwait = 1;
    tick();
    tick();
    iinval = 1; tick();
    iinval = 0; iwait = 0; tick();
    check("inval_rerequest", {31'b0, ihit}, 32'd0);
    miss_fill(32'h44, 0);
    tick();

    // Halt blocks a miss but still serves a hit.
    miss_fill(32'h40, 0);
    halt = 1; imemaddr = 32'h300;
    tick();
    tick();
    check("halt_no_iren", {31'b0, iREN}, 32'd0);
    imemaddr = 32'h40;
    tick();
    halt = 0;

    // Saturating hit counter.
    repeat (20) tick();
    check("hit_sat", 32'(hit_count), 32'd15);

    // Randomised traffic.
    for (int n = 0; n < 300; n++) begin
      imemREN  = ($urandom % 4) != 0;
      imemaddr = (($urandom % 3) << 6) | (($urandom % 4) << 2) | ($urandom % 4);
      halt     = ($urandom % 8) == 0;
      iinval   = ($urandom % 16) == 0;
      iwait    = ($urandom % 3) != 0;
      tick();
    end
    halt = 0; iinval = 0;

    // Asynchronous reset while a fill is in flight.
    miss_fill(32'h40, 0);
    imemaddr = 32'h500; iwait = 1;
    tick();
    tick();
    #2;
    check("pre_rst_iren", {31'b0, iREN}, 32'd1);
    RST = 1;
    #1;
    check("rst_async_iren", {31'b0, iREN}, 32'd0);
    check("rst_async_iaddr", iaddr, 32'h0);
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_miss_count", 32'(miss_count), 32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    RST = 0;
    imemaddr = 32'h40; iwait = 1;
    tick();
    check("post_rst_iren", {31'b0, iREN}, 32'd1);
    iwait = 0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
